mcpu_ctrl_seq: RTL and testbench

//  Multi-cycle control sequencer for the MCPU datapath: drives PC/IR/MDR/A/B/ALUOut enables, mux selects and ALU op.

---
 rtl/mcpu_ctrl_seq.sv | 159 +++++++++++++++
 tb/tb_mcpu_ctrl_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_ctrl_seq.sv
// mcpu_ctrl_seq: multi-cycle MCPU control sequencer with memory handshake, bus timeout, illegal-op halt and retire counter
module mcpu_ctrl_seq #(
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 16,
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_SUB = 3'd1,
  parameter logic [2:0] ALU_XOR = 3'd2,
  parameter logic [2:0] ALU_SLT = 3'd3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             a_we,
  output logic             b_we,
  output logic             aluout_we,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] TO_LAST = WW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD,
    WB_MEM, MEM_WR, BRANCH, JUMP, JAL, JR, HALT
  } state_t;
  state_t state;
  logic [WW-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic err;
  logic mem_wait, retire, timeout;
  assign mem_wait = (state == FETCH || state == MEM_RD || state == MEM_WR) && !mem_ready;
  assign retire = (state inside {WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR}) || (state == MEM_WR && mem_ready);
  assign timeout = TIMEOUT > 0 && mem_wait && wait_cnt == TO_LAST;
  assign halted = state == HALT && !reset;
  assign bus_err = err && !reset;
  assign instr_count = reset ? '0 : cnt;
  always_comb begin
    {mem_req, mem_we, iord, pc_we, ir_we, mdr_we, a_we, b_we, aluout_we, reg_we} = '0;
    reg_dst = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op = ALU_ADD;
    pc_src = 2'd0;
    if (!reset)
      case (state)
        FETCH: begin
          mem_req = 1'b1;
          alu_src_b = 2'd1;
          ir_we = mem_ready;
          pc_we = mem_ready;
        end
        DECODE: begin
          {a_we, b_we, aluout_we} = 3'b111;
          alu_src_b = 2'd3;
        end
        EXEC_R: begin
          alu_src_a = 2'd1;
          aluout_we = 1'b1;
          alu_op = funct == 6'h22 ? ALU_SUB : funct == 6'h2a ? ALU_SLT : ALU_ADD;
        end
        WB_R: begin
          reg_we = 1'b1;
          reg_dst = 2'd1;
        end
        EXEC_I: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          aluout_we = 1'b1;
          alu_op = opcode == 6'h0e ? ALU_XOR : ALU_ADD;
        end
        WB_I: reg_we = 1'b1;
        MEM_ADDR: begin
          alu_src_a = 2'd1;
          alu_src_b = 2'd2;
          aluout_we = 1'b1;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord = 1'b1;
          mdr_we = mem_ready;
        end
        WB_MEM: begin
          reg_we = 1'b1;
          mem_to_reg = 2'd1;
        end
        MEM_WR: {mem_req, mem_we, iord} = 3'b111;
        BRANCH: begin
          alu_src_a = 2'd1;
          alu_op = ALU_SUB;
          pc_src = 2'd1;
          pc_we = zero ^ (opcode == 6'h05);
        end
        JUMP: begin
          pc_src = 2'd2;
          pc_we = 1'b1;
        end
        JAL: begin
          pc_src = 2'd2;
          pc_we = 1'b1;
          reg_we = 1'b1;
          reg_dst = 2'd2;
          mem_to_reg = 2'd2;
        end
        JR: begin
          pc_src = 2'd3;
          pc_we = 1'b1;
        end
        default: ;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      wait_cnt <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      wait_cnt <= (TIMEOUT > 0 && mem_wait && !timeout) ? wait_cnt + 1'b1 : '0;
      if (retire) cnt <= cnt + 1'b1;
      if (timeout) begin
        err <= 1'b1;
        state <= HALT;
      end else
        case (state)
          FETCH: if (mem_ready) state <= DECODE;
          DECODE: state <= (opcode == 6'h00 && funct == 6'h08) ? JR :
                           (opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h2a)) ? EXEC_R :
                           (opcode == 6'h23 || opcode == 6'h2b) ? MEM_ADDR :
                           (opcode == 6'h08 || opcode == 6'h0e) ? EXEC_I :
                           (opcode == 6'h04 || opcode == 6'h05) ? BRANCH :
                           opcode == 6'h02 ? JUMP : opcode == 6'h03 ? JAL : HALT;
          EXEC_R: state <= WB_R;
          EXEC_I: state <= WB_I;
          MEM_ADDR: state <= opcode == 6'h23 ? MEM_RD : MEM_WR;
          MEM_RD: if (mem_ready) state <= WB_MEM;
          MEM_WR: if (mem_ready) state <= FETCH;
          HALT: state <= HALT;
          default: state <= FETCH;
        endcase
    end
  end
endmodule

// File: tb/tb_mcpu_ctrl_seq.sv
// tb_mcpu_ctrl_seq: directed self-checking bench for the multi-cycle control sequencer
module tb_mcpu_ctrl_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, iord, pc_we, ir_we, mdr_we, a_we, b_we, aluout_we, reg_we;
  logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic halted, bus_err;
  logic [31:0] instr_count;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  mcpu_ctrl_seq #(.CNT_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .pc_we(pc_we), .ir_we(ir_we), .mdr_we(mdr_we), .a_we(a_we), .b_we(b_we),
    .aluout_we(aluout_we), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .halted(halted), .bus_err(bus_err), .instr_count(instr_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    mem_ready = 1'b1;
    funct = 6'h20;
    tick;
    tick;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_bus_err", bus_err, 0);
    reset = 1'b0;
    #1;
    chk("add_f_mem_req", mem_req, 1);
    chk("add_f_ir_we", ir_we, 1);
    chk("add_f_pc_we", pc_we, 1);
    chk("add_f_src_b", alu_src_b, 1);
    chk("add_f_iord", iord, 0);
    tick; #1;
    chk("add_d_a_we", a_we, 1);
    chk("add_d_src_b", alu_src_b, 3);
    chk("add_d_mem_req", mem_req, 0);
    tick; #1;
    chk("add_x_src_a", alu_src_a, 1);
    chk("add_x_alu_op", alu_op, 0);
    chk("add_x_aluout_we", aluout_we, 1);
    tick; #1;
    chk("add_wb_reg_we", reg_we, 1);
    chk("add_wb_reg_dst", reg_dst, 1);
    chk("add_wb_mem_to_reg", mem_to_reg, 0);
    tick; #1;
    chk("add_count", instr_count, 1);
    chk("add_next_fetch", mem_req, 1);
    opcode = 6'h23;
    tick;
    tick; #1;
    chk("lw_addr_src_b", alu_src_b, 2);
    chk("lw_addr_aluout_we", aluout_we, 1);
    tick;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lw_wait_mem_req", mem_req, 1);
      chk("lw_wait_iord", iord, 1);
      chk("lw_wait_mdr_we", mdr_we, 0);
      tick;
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_rd_mdr_we", mdr_we, 1);
    chk("lw_rd_mem_req", mem_req, 1);
    tick; #1;
    chk("lw_wb_reg_we", reg_we, 1);
    chk("lw_wb_mem_to_reg", mem_to_reg, 1);
    chk("lw_wb_reg_dst", reg_dst, 0);
    tick; #1;
    chk("lw_count", instr_count, 2);
    opcode = 6'h2b;
    tick;
    tick;
    tick; #1;
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_req", mem_req, 1);
    chk("sw_iord", iord, 1);
    tick; #1;
    chk("sw_count", instr_count, 3);
    chk("sw_fetch_mem_we", mem_we, 0);
    opcode = 6'h04;
    zero = 1'b1;
    tick;
    tick; #1;
    chk("beq_pc_we", pc_we, 1);
    chk("beq_pc_src", pc_src, 1);
    chk("beq_alu_op", alu_op, 1);
    tick; #1;
    chk("beq_count", instr_count, 4);
    opcode = 6'h05;
    tick;
    tick; #1;
    chk("bne_z1_pc_we", pc_we, 0);
    zero = 1'b0;
    #1;
    chk("bne_z0_pc_we", pc_we, 1);
    tick; #1;
    chk("bne_count", instr_count, 5);
    opcode = 6'h03;
    tick;
    tick; #1;
    chk("jal_reg_we", reg_we, 1);
    chk("jal_reg_dst", reg_dst, 2);
    chk("jal_mem_to_reg", mem_to_reg, 2);
    chk("jal_pc_src", pc_src, 2);
    chk("jal_pc_we", pc_we, 1);
    tick; #1;
    chk("jal_count", instr_count, 6);
    opcode = 6'h0e;
    tick;
    tick; #1;
    chk("xori_alu_op", alu_op, 2);
    chk("xori_src_b", alu_src_b, 2);
    tick; #1;
    chk("xori_wb_reg_we", reg_we, 1);
    chk("xori_wb_reg_dst", reg_dst, 0);
    tick; #1;
    chk("xori_count", instr_count, 7);
    opcode = 6'h00;
    funct = 6'h22;
    tick;
    tick; #1;
    chk("sub_alu_op", alu_op, 1);
    tick;
    tick; #1;
    chk("sub_count", instr_count, 8);
    funct = 6'h08;
    tick;
    tick; #1;
    chk("jr_pc_src", pc_src, 3);
    chk("jr_pc_we", pc_we, 1);
    tick; #1;
    chk("jr_count", instr_count, 9);
    opcode = 6'h02;
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    #1;
    chk("to_edge_mem_req", mem_req, 1);
    chk("to_edge_bus_err", bus_err, 0);
    mem_ready = 1'b1;
    #1;
    chk("to_edge_ir_we", ir_we, 1);
    tick; #1;
    chk("to_edge_no_err", bus_err, 0);
    chk("to_edge_not_halted", halted, 0);
    tick; #1;
    chk("j_pc_src", pc_src, 2);
    chk("j_pc_we", pc_we, 1);
    tick; #1;
    chk("j_count", instr_count, 10);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick;
    #1;
    chk("to_pre_bus_err", bus_err, 0);
    chk("to_pre_mem_req", mem_req, 1);
    tick; #1;
    chk("to_bus_err", bus_err, 1);
    chk("to_halted", halted, 1);
    chk("to_mem_req", mem_req, 0);
    chk("to_count", instr_count, 10);
    mem_ready = 1'b1;
    tick;
    tick; #1;
    chk("to_hold_halted", halted, 1);
    chk("to_hold_mem_req", mem_req, 0);
    chk("to_hold_pc_we", pc_we, 0);
    reset = 1'b1;
    #1;
    chk("to_rst_halted", halted, 0);
    chk("to_rst_bus_err", bus_err, 0);
    chk("to_rst_count", instr_count, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("to_rst_fetch", mem_req, 1);
    chk("to_rst_err_clear", bus_err, 0);
    opcode = 6'h3f;
    tick;
    tick; #1;
    chk("ill_halted", halted, 1);
    chk("ill_mem_req", mem_req, 0);
    chk("ill_count", instr_count, 0);
    for (int i = 0; i < 3; i++) tick;
    #1;
    chk("ill_hold_halted", halted, 1);
    chk("ill_hold_mem_req", mem_req, 0);
    chk("ill_hold_ir_we", ir_we, 0);
    reset = 1'b1;
    #1;
    chk("ill_rst_halted", halted, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("ill_rst_fetch", mem_req, 1);
    chk("ill_rst_not_halted", halted, 0);
    opcode = 6'h23;
    tick;
    tick;
    tick;
    mem_ready = 1'b0;
    #1;
    chk("mid_rd_mem_req", mem_req, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_req", mem_req, 0);
    chk("mid_rst_iord", iord, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("mid_restart_mem_req", mem_req, 1);
    chk("mid_restart_iord", iord, 0);
    chk("mid_restart_count", instr_count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
